// File: rtl/kbd_player_ctrl.sv
// Keyboard command decoder for a playback engine: start/stop, direction,
// and a restart handshake with ack-or-timeout resolution.
module kbd_player_ctrl #(
  parameter int unsigned RESTART_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] kbd_data,
  input  logic       kbd_valid,
  input  logic       restart_ack,
  output logic       play,
  output logic       dir_fwd,
  output logic       restart_req,
  output logic       restart_done,
  output logic       restart_timeout,
  output logic       unknown_key
);

  // state  | meaning
  // R_IDLE | no restart pending; restart key opens a request
  // R_WAIT | restart_req held, counting cycles until ack or timeout
  typedef enum logic {
    R_IDLE,
    R_WAIT
  } rstate_t;

  typedef enum logic [2:0] {
    K_NONE,
    K_START,
    K_STOP,
    K_FWD,
    K_BACK,
    K_RESTART,
    K_OTHER
  } key_t;

  // Timeout fires on the cycle the counter would reach RESTART_TIMEOUT.
  localparam logic [15:0] CNT_LAST = 16'(RESTART_TIMEOUT - 1);

  rstate_t     state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  key_t        key;
  logic        play_nxt, dir_fwd_nxt, req_nxt;
  logic        done_nxt, tmo_nxt, unk_nxt;

  always_comb begin
    key = K_NONE;
    if (kbd_valid) begin
      unique case (kbd_data)
        8'h45, 8'h65: key = K_START;
        8'h44, 8'h64: key = K_STOP;
        8'h46, 8'h66: key = K_FWD;
        8'h42, 8'h62: key = K_BACK;
        8'h52, 8'h72: key = K_RESTART;
        default:      key = K_OTHER;
      endcase
    end
  end

  always_comb begin
    play_nxt    = play;
    dir_fwd_nxt = dir_fwd;
    unk_nxt     = 1'b0;
    unique case (key)
      K_START: play_nxt    = 1'b1;
      K_STOP:  play_nxt    = 1'b0;
      K_FWD:   dir_fwd_nxt = 1'b1;
      K_BACK:  dir_fwd_nxt = 1'b0;
      K_OTHER: unk_nxt     = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_nxt   = restart_req;
    done_nxt  = 1'b0;
    tmo_nxt   = 1'b0;
    unique case (state)
      R_IDLE: begin
        if (key == K_RESTART) begin
          state_nxt = R_WAIT;
          req_nxt   = 1'b1;
          cnt_nxt   = 16'd0;
        end
      end
      R_WAIT: begin
        // A restart key here is deliberately swallowed; ack wins over timeout.
        cnt_nxt = cnt + 16'd1;
        if (restart_ack) begin
          state_nxt = R_IDLE;
          req_nxt   = 1'b0;
          done_nxt  = 1'b1;
          cnt_nxt   = 16'd0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = R_IDLE;
          req_nxt   = 1'b0;
          tmo_nxt   = 1'b1;
          cnt_nxt   = 16'd0;
        end
      end
      default: begin
        state_nxt = R_IDLE;
        req_nxt   = 1'b0;
        cnt_nxt   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= R_IDLE;
      cnt             <= 16'd0;
      play            <= 1'b0;
      dir_fwd         <= 1'b1;
      restart_req     <= 1'b0;
      restart_done    <= 1'b0;
      restart_timeout <= 1'b0;
      unknown_key     <= 1'b0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      play            <= play_nxt;
      dir_fwd         <= dir_fwd_nxt;
      restart_req     <= req_nxt;
      restart_done    <= done_nxt;
      restart_timeout <= tmo_nxt;
      unknown_key     <= unk_nxt;
    end
  end

endmodule

// File: tb/tb_kbd_player_ctrl.sv
// Directed bench: one instance at the default timeout, one with a 4-cycle timeout.
module tb_kbd_player_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] kbd_data;
  logic       kbd_valid;
  logic       ack_a, ack_b;
  logic       play_a, dir_a, req_a, done_a, tmo_a, unk_a;
  logic       play_b, dir_b, req_b, done_b, tmo_b, unk_b;
  int         total = 0;
  int         bad = 0;

  kbd_player_ctrl dut_a (
    .clk(clk), .reset(reset), .kbd_data(kbd_data), .kbd_valid(kbd_valid),
    .restart_ack(ack_a), .play(play_a), .dir_fwd(dir_a), .restart_req(req_a),
    .restart_done(done_a), .restart_timeout(tmo_a), .unknown_key(unk_a)
  );

  kbd_player_ctrl #(.RESTART_TIMEOUT(4)) dut_b (
    .clk(clk), .reset(reset), .kbd_data(kbd_data), .kbd_valid(kbd_valid),
    .restart_ack(ack_b), .play(play_b), .dir_fwd(dir_b), .restart_req(req_b),
    .restart_done(done_b), .restart_timeout(tmo_b), .unknown_key(unk_b)
  );

  always #5 clk = ~clk;

  // Status word: {play, dir_fwd, restart_req, restart_done, restart_timeout, unknown_key}
  wire [5:0] st_a = {play_a, dir_a, req_a, done_a, tmo_a, unk_a};
  wire [5:0] st_b = {play_b, dir_b, req_b, done_b, tmo_b, unk_b};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [7:0] k);
    kbd_data  = k;
    kbd_valid = 1'b1;
    tick();
    kbd_valid = 1'b0;
    kbd_data  = 8'h00;
  endtask

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; kbd_valid = 1'b1; kbd_data = 8'h65; ack_a = 1'b1; ack_b = 1'b1;
    tick(); tick();
    chk("reset_prio_a", st_a, 6'b010000);
    chk("reset_prio_b", st_b, 6'b010000);
    reset = 1'b0; kbd_valid = 1'b0; kbd_data = 8'h00; ack_a = 1'b0; ack_b = 1'b0;
    tick();
    chk("reset_idle", st_a, 6'b010000);

    key(8'h65);  chk("start_e", st_a, 6'b110000);
    key(8'h45);  chk("start_repeat", st_a, 6'b110000);
    key(8'h42);  chk("back_B", st_a, 6'b100000);
    key(8'h64);  chk("stop_d", st_a, 6'b000000);
    key(8'h41);  chk("unknown_A", st_a, 6'b000001);
    tick();      chk("unknown_one_cycle", st_a, 6'b000000);
    key(8'hC5);  chk("no_partial_match", st_a, 6'b000001);
    key(8'h66);  chk("fwd_f", st_a, 6'b010000);
    kbd_data = 8'h65; kbd_valid = 1'b0;
    tick();      chk("valid_low_ignored", st_a, 6'b010000);
    kbd_data = 8'h00;
    ack_a = 1'b1;
    tick();      chk("ack_in_idle", st_a, 6'b010000);
    ack_a = 1'b0;

    key(8'h65);  chk("start_again", st_a, 6'b110000);
    key(8'h72);  chk("restart_req_up", st_a, 6'b111000);
    tick();      chk("wait_1", st_a, 6'b111000);
    key(8'h72);  chk("restart_in_wait", st_a, 6'b111000);
    key(8'h62);  chk("back_in_wait", st_a, 6'b101000);
    tick();      chk("wait_4", st_a, 6'b101000);
    ack_a = 1'b1;
    tick();      chk("restart_done", st_a, 6'b100100);
    ack_a = 1'b0;
    tick();      chk("done_one_cycle", st_a, 6'b100000);

    reset = 1'b1; tick(); reset = 1'b0;
    chk("b_reset", st_b, 6'b010000);
    key(8'h52);  chk("b_req_up", st_b, 6'b011000);
    tick();      chk("b_wait_1", st_b, 6'b011000);
    tick();      chk("b_wait_2", st_b, 6'b011000);
    tick();      chk("b_wait_3", st_b, 6'b011000);
    tick();      chk("b_timeout", st_b, 6'b010010);
    tick();      chk("b_timeout_one_cycle", st_b, 6'b010000);

    key(8'h52);  chk("b_req_up2", st_b, 6'b011000);
    tick(); tick(); tick();
    chk("b_before_last", st_b, 6'b011000);
    ack_b = 1'b1;
    tick();      chk("b_ack_beats_timeout", st_b, 6'b010100);
    ack_b = 1'b0;
    tick();      chk("b_after_ack", st_b, 6'b010000);

    key(8'h52);  chk("b_req_up3", st_b, 6'b011000);
    key(8'h72);  chk("b_rekey_ignored", st_b, 6'b011000);
    tick(); tick();
    chk("b_rekey_wait_3", st_b, 6'b011000);
    tick();      chk("b_rekey_no_cnt_reset", st_b, 6'b010010);

    key(8'h65); key(8'h62); key(8'h72);
    chk("pre_reset_a", st_a, 6'b101000);
    chk("pre_reset_b", st_b, 6'b101000);
    reset = 1'b1; ack_a = 1'b1; ack_b = 1'b1; kbd_data = 8'h65; kbd_valid = 1'b1;
    tick();
    chk("reset_mid_wait_a", st_a, 6'b010000);
    chk("reset_mid_wait_b", st_b, 6'b010000);
    reset = 1'b0; ack_a = 1'b0; ack_b = 1'b0; kbd_valid = 1'b0; kbd_data = 8'h00;
    tick();
    chk("post_reset_quiet", st_a, 6'b010000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kbd_player_ctrl.md
KBD_PLAYER_CTRL -- requirements
Module: kbd_player_ctrl

Interface
REQ-001 Parameter: RESTART_TIMEOUT, default 255, max cycles restart_req stays high awaiting restart_ack (legal range 1..65535).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 kbd_data  input  8  ASCII key code; valid only when kbd_valid=1.
REQ-005 kbd_valid  input  1  one-cycle strobe per key event.
REQ-006 restart_ack  input  1  player confirms address pointer returned to start.
REQ-007 play  output  1  level; 1 = playback running, 0 = paused.
REQ-008 dir_fwd  output  1  level; 1 = forward, 0 = backward.
REQ-009 restart_req  output  1  level; held high until acknowledged or timed out.
REQ-010 restart_done  output  1  one-cycle pulse on accepted restart_ack.
REQ-011 restart_timeout  output  1  one-cycle pulse on timeout abort.
REQ-012 unknown_key  output  1  one-cycle pulse on unrecognised code.

Function
REQ-013 The block SHALL decode case-insensitively: E/e (8'h45/8'h65) = start, D/d (8'h44/8'h64) = stop, F/f (8'h46/8'h66) = forward, B/b (8'h42/8'h62) = backward, R/r (8'h52/8'h72) = restart.
REQ-014 The block SHALL decode by exact 8-bit equality; no bitwise partial matching.
REQ-015 kbd_data SHALL be ignored when kbd_valid=0.
REQ-016 Latency SHALL be one cycle: a key sampled at edge N updates outputs at edge N+1.
REQ-017 Start SHALL set play=1; stop SHALL set play=0; repeats SHALL leave state unchanged.
REQ-018 Forward SHALL set dir_fwd=1; backward SHALL set dir_fwd=0; play SHALL be unaffected.
REQ-019 Any other code with kbd_valid=1 SHALL pulse unknown_key for exactly one cycle and change nothing else.
REQ-020 Restart FSM SHALL have two states, R_IDLE and R_WAIT.
REQ-021 In R_IDLE, restart SHALL move to R_WAIT, assert restart_req, and clear the 16-bit wait counter.
REQ-022 In R_WAIT, the counter SHALL increment every cycle.
REQ-023 In R_WAIT, restart_ack=1 SHALL deassert restart_req, pulse restart_done, and return to R_IDLE.
REQ-024 In R_WAIT, the counter reaching RESTART_TIMEOUT without ack SHALL deassert restart_req, pulse restart_timeout, and return to R_IDLE.
REQ-025 Ack and timeout in the same cycle SHALL resolve as ack: restart_done pulses, restart_timeout does not.
REQ-026 Restart key while in R_WAIT SHALL be ignored, with no counter reset and no unknown_key pulse.
REQ-027 restart_ack while in R_IDLE SHALL be ignored.
REQ-028 E/D/F/B keys SHALL take effect normally in either FSM state.
REQ-029 Restart SHALL NOT change play or dir_fwd.

Reset
REQ-030 Reset SHALL force, at the next edge: play=0, dir_fwd=1, restart_req=0, restart_done=0, restart_timeout=0, unknown_key=0, FSM=R_IDLE, counter=0.
REQ-031 Reset SHALL take priority over all inputs, including a simultaneous kbd_valid or restart_ack.
REQ-032 Reset asserted mid-R_WAIT SHALL drop restart_req with no done/timeout pulse.

Verification
REQ-033 After reset, kbd_data=8'h65 with kbd_valid for one cycle -> play=1 one cycle later, dir_fwd=1.
REQ-034 Keys 'B' then 'd' -> dir_fwd=0, then play=0; unknown_key stays 0 throughout.
REQ-035 Key 8'h41 ('A') -> unknown_key pulses one cycle; play and dir_fwd unchanged.
REQ-036 Key 'r', restart_ack returned 5 cycles later -> restart_req high for those cycles, then low with one restart_done pulse; second 'r' during wait has no effect.
REQ-037 RESTART_TIMEOUT=4, key 'R', no ack -> restart_req high 4 cycles, then one restart_timeout pulse; ack in the final cycle instead -> restart_done only.
REQ-038 Reset during R_WAIT with play=1, dir_fwd=0 -> next cycle restart_req=0, play=0, dir_fwd=1, no pulses.
